// File: rtl/serial_pattern_detector.sv
// Serial pattern detector: shifts qualified bits into a window, pulses match on PATTERN and counts matches.
// Optional build macro SERIAL_PATTERN_DETECTOR_SATURATE_EN makes match_count saturate instead of wrap.
module serial_pattern_detector #(
  parameter int                   PATTERN_W = 4,
  parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1011,
  parameter int                   OVERLAP   = 1,
  parameter int                   CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 din_valid,
  input  logic                 din,
  output logic [PATTERN_W-1:0] shreg,
  output logic                 armed,
  output logic                 match,
  output logic [CNT_W-1:0]     match_count
);

  localparam int FILL_W = $clog2(PATTERN_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PATTERN_W);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PATTERN_W - 1);

  typedef enum logic {
    FILL  = 1'b0,
    ARMED = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [PATTERN_W-1:0]   shreg_q, shreg_d;
  logic [FILL_W-1:0]      fill_q, fill_d;
  logic                   match_q, match_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [PATTERN_W-1:0]   next_win;
  logic                   hit;

  function automatic logic [CNT_W-1:0] bump_count(input logic [CNT_W-1:0] c);
`ifdef SERIAL_PATTERN_DETECTOR_SATURATE_EN
    return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
`else
    return c + CNT_W'(1);
`endif
  endfunction

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    fill_d   = fill_q;
    match_d  = 1'b0;
    count_d  = count_q;
    next_win = {shreg_q[PATTERN_W-2:0], din};
    // fill >= PATTERN_W-1 means this accept completes a full window of fresh bits
    hit      = din_valid && (fill_q >= FILL_LAST) && (next_win == PATTERN);

    if (clear) begin
      state_d = FILL;
      shreg_d = '0;
      fill_d  = '0;
      count_d = '0;
    end else if (din_valid) begin
      shreg_d = next_win;
      fill_d  = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
      if (fill_d == FILL_FULL) state_d = ARMED;
      if (hit) begin
        match_d = 1'b1;
        count_d = bump_count(count_q);
        if (OVERLAP == 0) begin
          shreg_d = '0;
          fill_d  = '0;
          state_d = FILL;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FILL;
      shreg_q <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      count_q <= count_d;
    end
  end

  assign shreg       = shreg_q;
  assign armed       = (state_q == ARMED);
  assign match       = match_q;
  assign match_count = count_q;

endmodule

// File: tb/tb_serial_pattern_detector.sv
// Bench for serial_pattern_detector: three instances (default, no-overlap, 2-bit counter)
// checked every cycle against a history-based reference model, plus directed spot checks.
module tb_serial_pattern_detector;

  localparam int PW = 4;
  localparam logic [3:0] PAT = 4'b1011;

  logic clk = 1'b0;
  logic reset = 1'b1, clear = 1'b0, din_valid = 1'b0, din = 1'b0;

  logic [3:0] shreg_a, shreg_b, shreg_c;
  logic       armed_a, armed_b, armed_c;
  logic       match_a, match_b, match_c;
  logic [7:0] cnt_a, cnt_b;
  logic [1:0] cnt_c;

  always #5 clk = ~clk;

  serial_pattern_detector dut_a (
    .clk(clk), .reset(reset), .clear(clear), .din_valid(din_valid), .din(din),
    .shreg(shreg_a), .armed(armed_a), .match(match_a), .match_count(cnt_a));

  serial_pattern_detector #(.OVERLAP(0)) dut_b (
    .clk(clk), .reset(reset), .clear(clear), .din_valid(din_valid), .din(din),
    .shreg(shreg_b), .armed(armed_b), .match(match_b), .match_count(cnt_b));

  serial_pattern_detector #(.CNT_W(2)) dut_c (
    .clk(clk), .reset(reset), .clear(clear), .din_valid(din_valid), .din(din),
    .shreg(shreg_c), .armed(armed_c), .match(match_c), .match_count(cnt_c));

  int checks = 0;
  int errors = 0;
  int pulses_c = 0;

  // Reference model: last accepted bits since reset/clear/flush, oldest first.
  int hlen[3];
  bit hist[3][4];
  int nmatch[3];
  bit exp_match[3];
  int ovl[3] = '{1, 0, 1};
  int cw[3]  = '{8, 8, 2};

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_step(input bit r, input bit c, input bit v, input bit d);
    for (int i = 0; i < 3; i++) begin
      if (r || c) begin
        hlen[i] = 0; nmatch[i] = 0; exp_match[i] = 1'b0;
      end else if (v) begin
        bit hit;
        if (hlen[i] < PW) begin
          hist[i][hlen[i]] = d;
          hlen[i]++;
        end else begin
          for (int k = 0; k < PW - 1; k++) hist[i][k] = hist[i][k+1];
          hist[i][PW-1] = d;
        end
        hit = (hlen[i] == PW);
        for (int k = 0; k < PW; k++) if (hist[i][k] != PAT[PW-1-k]) hit = 1'b0;
        exp_match[i] = hit;
        if (hit) begin
          nmatch[i]++;
          if (ovl[i] == 0) hlen[i] = 0;
        end
      end else begin
        exp_match[i] = 1'b0;
      end
    end
  endfunction

  function automatic logic [7:0] exp_shreg(input int i);
    logic [7:0] s = '0;
    for (int k = 0; k < hlen[i]; k++) s = {s[6:0], hist[i][k]};
    return s;
  endfunction

  function automatic logic [7:0] exp_cnt(input int i);
    int lim = (1 << cw[i]) - 1;
`ifdef SERIAL_PATTERN_DETECTOR_SATURATE_EN
    return 8'((nmatch[i] > lim) ? lim : nmatch[i]);
`else
    return 8'(nmatch[i] % (lim + 1));
`endif
  endfunction

  task automatic check_all();
    chk("a.shreg", {4'b0, shreg_a}, exp_shreg(0));
    chk("a.armed", {7'b0, armed_a}, {7'b0, hlen[0] == PW});
    chk("a.match", {7'b0, match_a}, {7'b0, exp_match[0]});
    chk("a.count", cnt_a, exp_cnt(0));
    chk("b.shreg", {4'b0, shreg_b}, exp_shreg(1));
    chk("b.armed", {7'b0, armed_b}, {7'b0, hlen[1] == PW});
    chk("b.match", {7'b0, match_b}, {7'b0, exp_match[1]});
    chk("b.count", cnt_b, exp_cnt(1));
    chk("c.shreg", {4'b0, shreg_c}, exp_shreg(2));
    chk("c.armed", {7'b0, armed_c}, {7'b0, hlen[2] == PW});
    chk("c.match", {7'b0, match_c}, {7'b0, exp_match[2]});
    chk("c.count", {6'b0, cnt_c}, exp_cnt(2));
    if (match_c === 1'b1) pulses_c++;
  endtask

  task automatic step(input bit r, input bit c, input bit v, input bit d);
    @(negedge clk);
    reset = r; clear = c; din_valid = v; din = d;
    @(posedge clk);
    #1;
    model_step(r, c, v, d);
    check_all();
  endtask

  task automatic accept(input bit d);
    step(1'b0, 1'b0, 1'b1, d);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst.count", cnt_a, 8'd0);
    chk("rst.shreg", {4'b0, shreg_a}, 8'd0);

    // Basic 1011 detection
    accept(1); accept(0); accept(1); accept(1);
    chk("t1.match", {7'b0, match_a}, 8'd1);
    chk("t1.count", cnt_a, 8'd1);
    chk("t1.shreg", {4'b0, shreg_a}, 8'b1011);
    chk("t1.armed", {7'b0, armed_a}, 8'd1);
    idle();
    chk("t1.pulse_end", {7'b0, match_a}, 8'd0);

    // Overlap versus flush
    do_reset();
    accept(1); accept(0); accept(1); accept(1);
    chk("t2.b_armed4", {7'b0, armed_b}, 8'd0);
    accept(0); accept(1); accept(1);
    chk("t2.a_count", cnt_a, 8'd2);
    chk("t2.b_count", cnt_b, 8'd1);
    chk("t2.b_armed7", {7'b0, armed_b}, 8'd0);

    // Idle cycles ignored
    do_reset();
    accept(1); idle(); accept(0); accept(1); idle();
    chk("t3.hold", {4'b0, shreg_a}, 8'b0101);
    accept(1);
    chk("t3.match", {7'b0, match_a}, 8'd1);
    chk("t3.count", cnt_a, 8'd1);

    // Clear wins over a valid bit
    do_reset();
    accept(1); accept(0); accept(1);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    chk("t4.match", {7'b0, match_a}, 8'd0);
    chk("t4.count", cnt_a, 8'd0);
    chk("t4.shreg", {4'b0, shreg_a}, 8'd0);
    chk("t4.armed", {7'b0, armed_a}, 8'd0);

    // Reset mid-stream loses partial window
    accept(0); accept(0); accept(0); accept(1); accept(1);
    do_reset();
    chk("t5.shreg", {4'b0, shreg_a}, 8'd0);
    chk("t5.armed", {7'b0, armed_a}, 8'd0);
    accept(1); accept(0); accept(1);
    chk("t5.armed3", {7'b0, armed_a}, 8'd0);
    chk("t5.nomatch", {7'b0, match_a}, 8'd0);
    accept(1);
    chk("t5.match", {7'b0, match_a}, 8'd1);
    chk("t5.count", cnt_a, 8'd1);

    // Counter wrap/saturate on the 2-bit instance
    do_reset();
    pulses_c = 0;
    accept(1); accept(0); accept(1); accept(1);
    for (int n = 0; n < 5; n++) begin
      accept(0); accept(1); accept(1);
    end
`ifdef SERIAL_PATTERN_DETECTOR_SATURATE_EN
    chk("t6.count", {6'b0, cnt_c}, 8'd3);
`else
    chk("t6.count", {6'b0, cnt_c}, 8'd2);
`endif
    chk("t6.pulses", 8'(pulses_c), 8'd6);

    // Randomized traffic
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      bit r, c, v, d;
      r = ($urandom_range(199) == 0);
      c = ($urandom_range(99) == 0);
      v = ($urandom_range(9) < 7);
      d = 1'($urandom_range(1));
      step(r, c, v, d);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
